// File: rtl/pwm_decoder_if.sv
// rtl/pwm_decoder_if.sv - pulse input and decoded outputs of the servo PWM decoder
// Purpose: groups the decoder's pulse input and result signals.
// Signals:
//   pwm_in : asynchronous servo pulse input (driven by master)
//   instr  : last decoded instruction, 10 back / 11 stop / 01 forward
//   valid  : one-cycle strobe, legal pulse decoded
//   width  : high time of the last legal pulse in ticks
//   err    : one-cycle strobe, pulse too short or too long
//   lost   : level, no rising edge within the timeout window
interface pwm_decoder_if;
  logic        pwm_in;
  logic [1:0]  instr;
  logic        valid;
  logic [11:0] width;
  logic        err;
  logic        lost;

  modport master (output pwm_in, input instr, valid, width, err, lost);
  modport slave  (input pwm_in, output instr, valid, width, err, lost);
endinterface

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures servo pulse high time and decodes the motor instruction
// Purpose: synchronizes pwm_in, measures each high pulse in clock ticks, classifies
//          it into back/stop/forward, flags illegal pulses and loss of signal.
// Ports:
//   clk   : system clock, one tick per cycle
//   reset : asynchronous active-low reset
//   bus   : pwm_decoder_if slave (pwm_in in; instr/valid/width/err/lost out)
module pwm_decoder #(
  parameter int MIN_W    = 100,
  parameter int BACK_MAX = 192,
  parameter int FWD_MIN  = 269,
  parameter int MAX_W    = 400,
  parameter int TIMEOUT  = 6144
) (
  input  logic         clk,
  input  logic         reset,
  pwm_decoder_if.slave bus
);

  localparam logic [1:0] ARM   = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] STUCK = 2'd3;

  localparam logic [11:0] MIN_W_C    = 12'(MIN_W);
  localparam logic [11:0] BACK_MAX_C = 12'(BACK_MAX);
  localparam logic [11:0] FWD_MIN_C  = 12'(FWD_MIN);
  localparam logic [11:0] MAX_W_C    = 12'(MAX_W);
  localparam logic [12:0] TIMEOUT_C  = 13'(TIMEOUT);

  localparam logic [1:0] INSTR_BACK = 2'b10;
  localparam logic [1:0] INSTR_STOP = 2'b11;
  localparam logic [1:0] INSTR_FWD  = 2'b01;

  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3
  logic [2:0]  sync_q;
  logic [1:0]  state_q, state_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [12:0] tcnt_q, tcnt_d;
  logic [1:0]  instr_q, instr_d;
  logic [11:0] width_q, width_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        lost_q, lost_d;

  logic s2, s3, rise, timeout_hit;

  assign s2   = sync_q[1];
  assign s3   = sync_q[2];
  assign rise = s2 & ~s3;

  // Synchronizer resets high: ARM must then observe a genuine low on the
  // input before arming, so a pulse in progress at reset release is never
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], bus.pwm_in};
    end
  end

  // Timeout fires on the cycle tcnt steps onto TIMEOUT, even if a rise
  // arrives in that same cycle; the pulse is still measured.
  assign timeout_hit = (state_q != ARM) && (tcnt_q == TIMEOUT_C - 13'd1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    instr_d = instr_q;
    width_d = width_q;
    lost_d  = lost_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (state_q == ARM || rise) begin
      tcnt_d = 13'd0;
    end else if (tcnt_q != TIMEOUT_C) begin
      tcnt_d = tcnt_q + 13'd1;
    end

    if (timeout_hit) begin
      lost_d  = 1'b1;
      instr_d = INSTR_STOP;
    end

    case (state_q)
      ARM: begin
        if (!s2) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          wcnt_d  = 12'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (s2) begin
          wcnt_d = wcnt_q + 12'd1;
          if (wcnt_q == MAX_W_C) begin
            err_d   = 1'b1;
            state_d = STUCK;
          end
        end else begin
          // Low while in HIGH is always the falling edge; wcnt <= MAX_W here.
          state_d = IDLE;
          if (wcnt_q >= MIN_W_C) begin
            valid_d = 1'b1;
            width_d = wcnt_q;
            lost_d  = 1'b0;
            if (wcnt_q <= BACK_MAX_C)     instr_d = INSTR_BACK;
            else if (wcnt_q >= FWD_MIN_C) instr_d = INSTR_FWD;
            else                          instr_d = INSTR_STOP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STUCK: begin
        if (!s2) state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARM;
      wcnt_q  <= 12'd0;
      tcnt_q  <= 13'd0;
      instr_q <= INSTR_STOP;
      width_q <= 12'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      instr_q <= instr_d;
      width_q <= width_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.instr = instr_q;
  assign bus.valid = valid_q;
  assign bus.width = width_q;
  assign bus.err   = err_q;
  assign bus.lost  = lost_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - self-checking bench for pwm_decoder
module tb_pwm_decoder;

  typedef struct {
    logic        is_err;
    logic [1:0]  instr;
    logic [11:0] width;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t sb[$];
  logic [1:0]  m_instr = 2'b11;
  logic [11:0] m_width = 12'd0;

  pwm_decoder_if bus ();

  pwm_decoder dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] decode(input int w);
    if (w <= 192) return 2'b10;
    if (w >= 269) return 2'b01;
    return 2'b11;
  endfunction

  task automatic push_valid(input int w);
    exp_t e;
    m_instr  = decode(w);
    m_width  = 12'(w);
    e.is_err = 1'b0;
    e.instr  = m_instr;
    e.width  = m_width;
    e.cyc    = -1;
    sb.push_back(e);
  endtask

  task automatic push_err(input int at_cyc);
    exp_t e;
    e.is_err = 1'b1;
    e.instr  = m_instr;
    e.width  = m_width;
    e.cyc    = at_cyc;
    sb.push_back(e);
  endtask

  // Drives high for hi cycles then low for lo cycles, starting on a negedge.
  task automatic pulse(input int hi, input int lo);
    bus.pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic frame(input int hi);
    push_valid(hi);
    pulse(hi, 3072 - hi);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.valid || bus.err)) begin
      check("strobe_exclusive", int'(bus.valid & bus.err), 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", int'({bus.valid, bus.err}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind_err", int'(bus.err), int'(e.is_err));
        check("strobe_instr", int'(bus.instr), int'(e.instr));
        check("strobe_width", int'(bus.width), int'(e.width));
        if (e.cyc >= 0) check("err_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int k;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_instr", int'(bus.instr), 3);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_width", int'(bus.width), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_lost", int'(bus.lost), 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("lost_before_first", int'(bus.lost), 1);

    frame(154);
    check("lost_after_first", int'(bus.lost), 0);
    check("instr_154", int'(bus.instr), 2);
    check("width_154", int'(bus.width), 154);
    frame(154);

    frame(230); check("instr_230", int'(bus.instr), 3);
    frame(307); check("instr_307", int'(bus.instr), 1);
    frame(192); check("instr_192", int'(bus.instr), 2);
    frame(193); check("instr_193", int'(bus.instr), 3);
    frame(269); check("instr_269", int'(bus.instr), 1);
    check("width_269", int'(bus.width), 269);

    // Short glitch after a 307 pulse.
    frame(307);
    push_err(-1);
    pulse(50, 3022);
    check("glitch_instr_kept", int'(bus.instr), 1);
    check("glitch_width_kept", int'(bus.width), 307);

    // Stuck high: err 403 posedges after the input rises (2 sync + 1 + 400).
    push_err(cyc + 403);
    pulse(600, 2472);
    check("stuck_sb_drained", sb.size(), 0);
    frame(230);
    check("after_stuck_instr", int'(bus.instr), 3);

    // Loss of signal: lost 6147 posedges after the last input rise.
    push_valid(307);
    k = cyc;
    pulse(307, 10);
    while (cyc < k + 6146) @(negedge clk);
    check("lost_pre_timeout", int'(bus.lost), 0);
    check("instr_pre_timeout", int'(bus.instr), 1);
    @(negedge clk);
    check("lost_at_timeout", int'(bus.lost), 1);
    check("instr_at_timeout", int'(bus.instr), 3);
    m_instr = 2'b11;
    repeat (50) @(negedge clk);
    frame(154);
    check("lost_recovered", int'(bus.lost), 0);
    check("instr_recovered", int'(bus.instr), 2);

    // Reset 100 ticks into a pulse, released at tick 120.
    bus.pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_instr", int'(bus.instr), 3);
    check("midrst_width", int'(bus.width), 0);
    check("midrst_lost", int'(bus.lost), 1);
    check("midrst_valid", int'(bus.valid), 0);
    check("midrst_err", int'(bus.err), 0);
    m_instr = 2'b11;
    m_width = 12'd0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    pulse(34, 2918);
    check("midrst_lost_held", int'(bus.lost), 1);
    frame(269);
    check("post_rst_instr", int'(bus.instr), 1);
    check("post_rst_width", int'(bus.width), 269);
    check("post_rst_lost", int'(bus.lost), 0);

    repeat (5) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator. Measures the high time of an incoming 50 Hz servo-style pulse train, nominally 154/230/307 ticks in a 3072-tick frame.
- Classifies each pulse back into the 2-bit motor instruction encoding: 10 back, 11 stop, 01 forward.
- Used for loopback checking of the motor path and for accepting commands from an external RC receiver. Same clock/tick rate as the generator.

Parameters:
- MIN_W, 100: shortest legal pulse in ticks; anything shorter is a glitch.
- BACK_MAX, 192: widths MIN_W..BACK_MAX decode to back (10).
- FWD_MIN, 269: widths FWD_MIN..MAX_W decode to forward (01). Widths BACK_MAX+1..FWD_MIN-1 decode to stop (11).
- MAX_W, 400: longest legal pulse in ticks.
- TIMEOUT, 6144: ticks with no rising edge before signal is declared lost (two frames).
- Constraint: MIN_W < BACK_MAX < FWD_MIN <= MAX_W < TIMEOUT <= 8191.

Ports:
- clk  in  1  system clock, one tick per cycle.
- reset  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous pulse input.
- instr  out  2  last decoded instruction; 10/11/01.
- valid  out  1  one-cycle strobe, high when a legal pulse has just been decoded.
- width  out  12  measured high time of the last legal pulse, in ticks.
- err  out  1  one-cycle strobe: illegal pulse (too short or too long).
- lost  out  1  level: no rising edge within TIMEOUT ticks.

Behaviour:
- Reset (reset low, async) forces: instr=11, valid=0, width=0, err=0, lost=1, state=ARM, all counters 0.
- Input path:
  - pwm_in passes through a 2-flop synchronizer (s1, s2), plus s3 for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed 3-cycle input-to-decision latency on both edges, so the measured width equals input high cycles exactly.
- States:
  - ARM: wait for s2=0, then go to IDLE. This discards a pulse already in progress at reset release.
  - IDLE: on rise, set wcnt=1 and go to HIGH.
  - HIGH: while s2=1, wcnt increments.
    - fall with MIN_W <= wcnt <= MAX_W: width=wcnt, instr per decode table, valid=1 for one cycle, lost=0, go to IDLE.
    - fall with wcnt < MIN_W: err=1 for one cycle; instr, width and lost unchanged; go to IDLE.
    - wcnt reaches MAX_W+1 while still high: err=1 for one cycle, go to STUCK.
  - STUCK: wait for fall with no further strobes, then go to IDLE.
- Counter widths: wcnt is 12 bits. It never exceeds MAX_W+1, so no wrap.
- Decode boundaries are inclusive as listed in Parameters: 192 gives 10, 193 gives 11, 268 gives 11, 269 gives 01.
- Timeout:
  - tcnt is 13 bits. It clears on every rise, otherwise increments and saturates at TIMEOUT.
  - When tcnt reaches TIMEOUT: lost=1 and instr=11, both registered in the same cycle.
  - lost clears only on the next valid.
  - Timeout applies in every state except ARM after reset, where lost is already 1.
- valid and err are never high in the same cycle.
- valid/err strobes coincide with the state transition out of HIGH.
- instr and width change only on valid, on timeout (instr only), or on reset.
- Reset mid-pulse: all outputs return to reset values immediately. After release the block re-enters ARM, so the remainder of that pulse produces no strobe.
- A rise in the same cycle as timeout: timeout takes effect (lost=1, instr=11), and the pulse is still measured normally.

Test Plan:
- 3072-tick frames with high time 154 → valid once per frame, instr=10, width=154, lost 1→0 on first pulse.
- Frames with 230, then 307, then 192, then 193, then 269 → instr 11, 01, 10, 11, 01; width matches each.
- 50-tick pulse after a 307 pulse → err one cycle, no valid, instr stays 01, width stays 307.
- pwm_in held high 600 ticks → err exactly once, 401 ticks after rise is registered; no strobe on the eventual fall. Next 230 pulse → valid, instr=11.
- 307 pulses then pwm_in held low → lost=1 and instr=11 exactly 6144 cycles after the last registered rise. Next 154 pulse → lost=0, instr=10.
- Assert reset 100 ticks into a pulse, release at tick 120 → outputs at reset values. No strobe for that pulse. The following frame decodes normally.
